// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage state encodings and default widths.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_IDX_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory request.
// expired is high while the count sits at TIMEOUT-1.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT - 1));

  // Count REQ cycles; restart whenever no request is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a req/ack data-memory bus, stalls the
// upstream pipeline while an access is outstanding, and owns the MEM/WB register.
// Optional macro MEM_ACCESS_ALIGN_CHECK_EN: reject misaligned accesses with an
// align_err pulse instead of issuing them word-aligned.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 MEM_RegWrite,
  input  logic                 MEM_MemtoReg,
  input  logic                 MEM_MemWrite,
  input  logic [DATA_W-1:0]    MEM_ALUOut,
  input  logic [DATA_W-1:0]    MEM_wmData,
  input  logic [REG_IDX_W-1:0] MEM_wrAddr,
  output logic                 mem_stall,
  output logic                 dm_req,
  output logic                 dm_we,
  output logic [DATA_W-1:0]    dm_addr,
  output logic [DATA_W-1:0]    dm_wdata,
  input  logic                 dm_ack,
  input  logic [DATA_W-1:0]    dm_rdata,
  output logic                 WB_RegWrite,
  output logic                 WB_MemtoReg,
  output logic [DATA_W-1:0]    WB_ALUOut,
  output logic [DATA_W-1:0]    WB_rdData,
  output logic [REG_IDX_W-1:0] WB_wrAddr,
  output logic                 bus_err,
  output logic                 align_err
);

  mem_state_t state;
  logic       acc;
  logic       align_fault;
  logic       aborted;
  logic       expired;

  assign acc = MEM_MemtoReg | MEM_MemWrite;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign align_fault = acc & (|MEM_ALUOut[1:0]);
`else
  assign align_fault = 1'b0;
`endif

  // Stall from access acceptance until the cycle the response is taken;
  // DONE releases the pipeline so EX/MEM advances exactly once.
  assign mem_stall = rst_n &
                     (((state == ST_IDLE) & acc & ~align_fault) | (state == ST_REQ));

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != ST_REQ),
    .en     (state == ST_REQ),
    .expired(expired)
  );

  // Access FSM together with the bus registers and the MEM/WB register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      aborted     <= 1'b0;
      bus_err     <= 1'b0;
      align_err   <= 1'b0;
      WB_RegWrite <= 1'b0;
      WB_MemtoReg <= 1'b0;
      WB_ALUOut   <= '0;
      WB_rdData   <= '0;
      WB_wrAddr   <= '0;
    end else begin
      align_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (align_fault) begin
            WB_RegWrite <= 1'b0;
            WB_MemtoReg <= MEM_MemtoReg;
            WB_ALUOut   <= MEM_ALUOut;
            WB_rdData   <= '0;
            WB_wrAddr   <= MEM_wrAddr;
            align_err   <= 1'b1;
          end else if (acc) begin
            WB_RegWrite <= 1'b0;
            dm_req      <= 1'b1;
            dm_we       <= MEM_MemWrite;
            dm_addr     <= {MEM_ALUOut[DATA_W-1:2], 2'b00};
            dm_wdata    <= MEM_wmData;
            aborted     <= 1'b0;
            state       <= ST_REQ;
          end else begin
            WB_RegWrite <= MEM_RegWrite;
            WB_MemtoReg <= MEM_MemtoReg;
            WB_ALUOut   <= MEM_ALUOut;
            WB_rdData   <= '0;
            WB_wrAddr   <= MEM_wrAddr;
          end
        end
        ST_REQ: begin
          WB_RegWrite <= 1'b0;
          // ack has priority over a coincident timeout
          if (dm_ack) begin
            if (!dm_we) WB_rdData <= dm_rdata;
            dm_req <= 1'b0;
            state  <= ST_DONE;
          end else if (expired) begin
            dm_req  <= 1'b0;
            bus_err <= 1'b1;
            aborted <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          WB_RegWrite <= aborted ? 1'b0 : MEM_RegWrite;
          WB_MemtoReg <= MEM_MemtoReg;
          WB_ALUOut   <= MEM_ALUOut;
          WB_wrAddr   <= MEM_wrAddr;
          if (aborted) WB_rdData <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (TIMEOUT overridden to 8).
// Honours MEM_ACCESS_ALIGN_CHECK_EN the same way the design does.
module tb_mem_access_unit;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_RegWrite, MEM_MemtoReg, MEM_MemWrite;
  logic [31:0] MEM_ALUOut, MEM_wmData;
  logic [4:0]  MEM_wrAddr;
  logic        mem_stall, dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        WB_RegWrite, WB_MemtoReg;
  logic [31:0] WB_ALUOut, WB_rdData;
  logic [4:0]  WB_wrAddr;
  logic        bus_err, align_err;

  int unsigned tests = 0;
  int unsigned fails = 0;
  bit          bus_err_m = 1'b0;

  mem_access_unit #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg), .MEM_MemWrite(MEM_MemWrite),
    .MEM_ALUOut(MEM_ALUOut), .MEM_wmData(MEM_wmData), .MEM_wrAddr(MEM_wrAddr),
    .mem_stall(mem_stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg), .WB_ALUOut(WB_ALUOut),
    .WB_rdData(WB_rdData), .WB_wrAddr(WB_wrAddr), .bus_err(bus_err), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // Presents one instruction to MEM and acts as the memory: ack comes on the
  // (delay+1)-th request cycle. Returns what it observed; no checking here.
  task automatic issue(input logic rw, input logic mr, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wa,
                       input int unsigned delay, input logic [31:0] rd,
                       output int unsigned stalls, output int unsigned reqs,
                       output bit stable, output logic [31:0] s_addr,
                       output logic s_we, output logic [31:0] s_wdata, output bit hung);
    bit st;
    MEM_RegWrite = rw; MEM_MemtoReg = mr; MEM_MemWrite = mw;
    MEM_ALUOut = alu; MEM_wmData = wd; MEM_wrAddr = wa;
    stalls = 0; reqs = 0; stable = 1'b1; hung = 1'b1;
    s_addr = '0; s_we = 1'b0; s_wdata = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dm_req) begin
        if (reqs == 0) begin
          s_addr = dm_addr; s_we = dm_we; s_wdata = dm_wdata;
        end else if (dm_addr !== s_addr || dm_we !== s_we || dm_wdata !== s_wdata) begin
          stable = 1'b0;
        end
        reqs++;
        dm_ack   = (reqs == delay + 1);
        dm_rdata = dm_ack ? rd : $urandom;
      end else begin
        dm_ack   = 1'b0;
        dm_rdata = $urandom;
      end
      st = mem_stall;
      if (st) stalls++;
      @(posedge clk);
      #1;
      if (!st) begin
        hung = 1'b0;
        break;
      end
    end
    dm_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    MEM_RegWrite = 1'b1; MEM_MemtoReg = 1'b1; MEM_MemWrite = 1'b0;
    MEM_ALUOut = 32'h100; MEM_wmData = '0; MEM_wrAddr = 5'd3;
    dm_ack = 1'b0; dm_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (mem_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", mem_stall); end
    tests++;
    if ({dm_req, dm_we, dm_addr, dm_wdata} !== '0) begin
      fails++; $display("FAIL reset_bus got req=%b we=%b addr=%h wdata=%h want 0", dm_req, dm_we, dm_addr, dm_wdata);
    end
    tests++;
    if ({WB_RegWrite, WB_MemtoReg, WB_ALUOut, WB_rdData, WB_wrAddr} !== '0) begin
      fails++; $display("FAIL reset_wb got rw=%b mr=%b alu=%h rd=%h wa=%0d want 0", WB_RegWrite, WB_MemtoReg, WB_ALUOut, WB_rdData, WB_wrAddr);
    end
    tests++;
    if ({bus_err, align_err} !== 2'b00) begin fails++; $display("FAIL reset_err got %b%b want 00", bus_err, align_err); end
    MEM_MemtoReg = 1'b0; MEM_RegWrite = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu;
    int unsigned s, r; bit stb, h; logic [31:0] a, w; logic we;
    issue(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 0, 32'h0, s, r, stb, a, we, w, h);
    tests++;
    if (h || s != 0 || r != 0) begin fails++; $display("FAIL alu_flow got stalls=%0d reqs=%0d hung=%b want 0 0 0", s, r, h); end
    tests++;
    if (WB_ALUOut !== 32'h1234 || WB_RegWrite !== 1'b1 || WB_wrAddr !== 5'd5 || WB_rdData !== '0) begin
      fails++; $display("FAIL alu_wb got alu=%h rw=%b wa=%0d rd=%h want 1234 1 5 0", WB_ALUOut, WB_RegWrite, WB_wrAddr, WB_rdData);
    end
  endtask

  task automatic test_load;
    int unsigned s, r; bit stb, h; logic [31:0] a, w; logic we;
    issue(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 0, 32'hDEADBEEF, s, r, stb, a, we, w, h);
    tests++;
    if (h || s != 2 || r != 1) begin fails++; $display("FAIL load_flow got stalls=%0d reqs=%0d hung=%b want 2 1 0", s, r, h); end
    tests++;
    if (a !== 32'h100 || we !== 1'b0) begin fails++; $display("FAIL load_bus got addr=%h we=%b want 100 0", a, we); end
    tests++;
    if (WB_rdData !== 32'hDEADBEEF || WB_MemtoReg !== 1'b1 || WB_RegWrite !== 1'b1 || WB_wrAddr !== 5'd7) begin
      fails++; $display("FAIL load_wb got rd=%h mr=%b rw=%b wa=%0d want deadbeef 1 1 7", WB_rdData, WB_MemtoReg, WB_RegWrite, WB_wrAddr);
    end
  endtask

  task automatic test_store;
    int unsigned s, r; bit stb, h; logic [31:0] a, w; logic we;
    issue(1'b0, 1'b0, 1'b1, 32'h200, 32'hA5A5A5A5, 5'd0, 4, 32'h0, s, r, stb, a, we, w, h);
    tests++;
    if (h || s != 6 || r != 5) begin fails++; $display("FAIL store_flow got stalls=%0d reqs=%0d hung=%b want 6 5 0", s, r, h); end
    tests++;
    if (!stb || a !== 32'h200 || we !== 1'b1 || w !== 32'hA5A5A5A5) begin
      fails++; $display("FAIL store_bus got stable=%b addr=%h we=%b wdata=%h want 1 200 1 a5a5a5a5", stb, a, we, w);
    end
    tests++;
    if (WB_RegWrite !== 1'b0 || bus_err !== 1'b0) begin fails++; $display("FAIL store_wb got rw=%b bus_err=%b want 0 0", WB_RegWrite, bus_err); end
  endtask

  task automatic test_timeout;
    int unsigned s, r; bit stb, h; logic [31:0] a, w; logic we;
    // ack on the last permitted cycle still wins
    issue(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd9, TO - 1, 32'h13579BDF, s, r, stb, a, we, w, h);
    tests++;
    if (h || r != TO || bus_err !== 1'b0 || WB_rdData !== 32'h13579BDF || WB_RegWrite !== 1'b1) begin
      fails++; $display("FAIL ack_at_limit got reqs=%0d bus_err=%b rd=%h rw=%b want %0d 0 13579bdf 1", r, bus_err, WB_rdData, WB_RegWrite, TO);
    end
    issue(1'b1, 1'b1, 1'b0, 32'h304, 32'h0, 5'd10, 1000, 32'h0, s, r, stb, a, we, w, h);
    bus_err_m = 1'b1;
    tests++;
    if (h || r != TO || s != TO + 1) begin fails++; $display("FAIL timeout_flow got reqs=%0d stalls=%0d hung=%b want %0d %0d 0", r, s, h, TO, TO + 1); end
    tests++;
    if (bus_err !== 1'b1 || WB_RegWrite !== 1'b0 || WB_rdData !== '0) begin
      fails++; $display("FAIL timeout_wb got bus_err=%b rw=%b rd=%h want 1 0 0", bus_err, WB_RegWrite, WB_rdData);
    end
    issue(1'b1, 1'b0, 1'b0, 32'hCAFE, 32'h0, 5'd11, 0, 32'h0, s, r, stb, a, we, w, h);
    tests++;
    if (h || s != 0 || WB_RegWrite !== 1'b1 || WB_ALUOut !== 32'hCAFE || bus_err !== 1'b1) begin
      fails++; $display("FAIL after_timeout got stalls=%0d rw=%b alu=%h bus_err=%b want 0 1 cafe 1", s, WB_RegWrite, WB_ALUOut, bus_err);
    end
  endtask

  task automatic test_reset_mid;
    int unsigned s, r; bit stb, h; logic [31:0] a, w; logic we;
    MEM_RegWrite = 1'b1; MEM_MemtoReg = 1'b1; MEM_MemWrite = 1'b0;
    MEM_ALUOut = 32'h400; MEM_wrAddr = 5'd12; dm_ack = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (dm_req !== 1'b1 || mem_stall !== 1'b1) begin fails++; $display("FAIL mid_pre got req=%b stall=%b want 1 1", dm_req, mem_stall); end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (dm_req !== 1'b0 || mem_stall !== 1'b0 || bus_err !== 1'b0) begin
      fails++; $display("FAIL mid_reset got req=%b stall=%b bus_err=%b want 0 0 0", dm_req, mem_stall, bus_err);
    end
    bus_err_m = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd12, 1, 32'h600DF00D, s, r, stb, a, we, w, h);
    tests++;
    if (h || s != 3 || r != 2 || a !== 32'h400 || WB_rdData !== 32'h600DF00D) begin
      fails++; $display("FAIL mid_reissue got stalls=%0d reqs=%0d addr=%h rd=%h want 3 2 400 600df00d", s, r, a, WB_rdData);
    end
  endtask

  task automatic test_align;
    int unsigned s, r; bit stb, h; logic [31:0] a, w; logic we;
    issue(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd4, 0, 32'h87654321, s, r, stb, a, we, w, h);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    tests++;
    if (h || s != 0 || r != 0 || align_err !== 1'b1 || WB_RegWrite !== 1'b0) begin
      fails++; $display("FAIL align_reject got stalls=%0d reqs=%0d align_err=%b rw=%b want 0 0 1 0", s, r, align_err, WB_RegWrite);
    end
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 32'h0, s, r, stb, a, we, w, h);
    tests++;
    if (align_err !== 1'b0) begin fails++; $display("FAIL align_pulse got %b want 0", align_err); end
`else
    tests++;
    if (h || r != 1 || a !== 32'h100 || align_err !== 1'b0 || WB_rdData !== 32'h87654321) begin
      fails++; $display("FAIL align_ignored got reqs=%0d addr=%h align_err=%b rd=%h want 1 100 0 87654321", r, a, align_err, WB_rdData);
    end
`endif
  endtask

  // Random mix checked against latency/result rules computed per instruction.
  task automatic test_random;
    int unsigned s, r, delay, e_reqs, e_stalls;
    bit stb, h, to, mis;
    logic [31:0] a, w, alu, wd, rd, e_rd;
    logic we, rw, mr, mw, e_rw, e_align, chk_rd;
    logic [4:0] wa;
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom); wa = 5'($urandom);
      case ($urandom_range(0, 2))
        0: begin mr = 1'b0; mw = 1'b0; end
        1: begin mr = 1'b1; mw = 1'b0; end
        default: begin mr = 1'b0; mw = 1'b1; rw = 1'b0; end
      endcase
      alu = $urandom; if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      wd = $urandom; rd = $urandom;
      delay = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 1, TO + 3) : $urandom_range(0, 3);
      mis = (alu % 4) != 0;
      to = delay >= TO;
      e_reqs = 0; e_stalls = 0; e_rw = rw; e_rd = 32'h0; chk_rd = 1'b1; e_align = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      if ((mr || mw) && mis) begin
        e_rw = 1'b0; e_align = 1'b1;
      end else
`endif
      if (mr || mw) begin
        e_reqs = to ? TO : delay + 1;
        e_stalls = e_reqs + 1;
        if (to) begin e_rw = 1'b0; bus_err_m = 1'b1; end
        else if (mr) e_rd = rd;
        else chk_rd = 1'b0;
      end
      issue(rw, mr, mw, alu, wd, wa, delay, rd, s, r, stb, a, we, w, h);
      tests++;
      if (h || s != e_stalls || r != e_reqs || !stb) begin
        fails++; $display("FAIL rnd%0d_flow got stalls=%0d reqs=%0d stable=%b hung=%b want %0d %0d 1 0", i, s, r, stb, h, e_stalls, e_reqs);
      end
      if (e_reqs != 0) begin
        tests++;
        if (a !== (alu - (alu % 4)) || we !== mw || (mw && w !== wd)) begin
          fails++; $display("FAIL rnd%0d_bus got addr=%h we=%b wdata=%h want %h %b %h", i, a, we, w, alu - (alu % 4), mw, wd);
        end
      end
      tests++;
      if (WB_RegWrite !== e_rw || WB_MemtoReg !== mr || WB_ALUOut !== alu || WB_wrAddr !== wa ||
          (chk_rd && WB_rdData !== e_rd) || bus_err !== bus_err_m || align_err !== e_align) begin
        fails++; $display("FAIL rnd%0d_wb got rw=%b mr=%b alu=%h wa=%0d rd=%h be=%b ae=%b want %b %b %h %0d %h %b %b",
                          i, WB_RegWrite, WB_MemtoReg, WB_ALUOut, WB_wrAddr, WB_rdData, bus_err, align_err,
                          e_rw, mr, alu, wa, e_rd, bus_err_m, e_align);
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load;
    test_store;
    test_timeout;
    test_reset_mid;
    test_align;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
